// File: rtl/psram_sched_pkg.sv
// psram_sched_pkg: shared encodings for the PSRAM transaction scheduler.
// FSM states, core command type codes, arbiter grant encodings and a
// helper that builds a command type from (is_mem, wr).
package psram_sched_pkg;

    typedef enum logic [1:0] {
        PSRAM_SCHED_IDLE  = 2'd0,
        PSRAM_SCHED_ISSUE = 2'd1,
        PSRAM_SCHED_WAIT  = 2'd2,
        PSRAM_SCHED_GAP   = 2'd3
    } sched_state_t;

    // Command codes are laid out as {is_mem, wr} so cmd_type() is a concat.
    localparam logic [1:0] PSRAM_CMD_CFG_RD = 2'd0;
    localparam logic [1:0] PSRAM_CMD_CFG_WR = 2'd1;
    localparam logic [1:0] PSRAM_CMD_MEM_RD = 2'd2;
    localparam logic [1:0] PSRAM_CMD_MEM_WR = 2'd3;

    typedef enum logic {
        PSRAM_GNT_CFG = 1'b0,
        PSRAM_GNT_MEM = 1'b1
    } grant_t;

    function automatic logic [1:0] cmd_type(input logic is_mem, input logic wr);
        return {is_mem, wr};
    endfunction

endpackage

// File: rtl/psram_sched_rr_arb2.sv
// psram_sched_rr_arb2: two-requester round-robin arbiter (config vs memory).
// Grants are combinational from the requests and the last_grant register;
// on a contest the requester opposite to last_grant wins. Reset leaves
// last_grant at MEM so config wins the first contest.
module psram_sched_rr_arb2
    import psram_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic cfg_req,
    input  logic mem_req,
    output logic cfg_gnt,
    output logic mem_gnt
);

    grant_t last_grant;

    assign cfg_gnt = enable & cfg_req & (~mem_req | (last_grant == PSRAM_GNT_MEM));
    assign mem_gnt = enable & mem_req & (~cfg_req | (last_grant == PSRAM_GNT_CFG));

    // Remember who was served last so the other side wins the next contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PSRAM_GNT_MEM;
        end else if (cfg_gnt) begin
            last_grant <= PSRAM_GNT_CFG;
        end else if (mem_gnt) begin
            last_grant <= PSRAM_GNT_MEM;
        end
    end

endmodule

// File: rtl/psram_sched.sv
// psram_sched: transaction scheduler in front of the PSRAM OPI core.
// Arbitrates config and memory requests, issues one command at a time,
// waits for core completion and enforces a minimum CE-high gap.
// Optional macro PSRAM_BURST_SPLIT_EN: split long memory bursts into
// chunks of max_beats_i+1 beats (max_beats_i ignored when undefined).
module psram_sched
    import psram_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 4,
    parameter int BEAT_BYTES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic                  cfg_wr_i,
    input  logic [7:0]            cfg_ma_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [LEN_WIDTH-1:0]  mem_len_i,
    input  logic [GAP_WIDTH-1:0]  tcph_i,
    input  logic [LEN_WIDTH-1:0]  max_beats_i,
    output logic                  core_start_o,
    output logic [1:0]            core_type_o,
    output logic [ADDR_WIDTH-1:0] core_addr_o,
    output logic [LEN_WIDTH-1:0]  core_len_o,
    input  logic                  core_done_i,
    output logic                  cfg_done_o,
    output logic                  mem_done_o,
    output logic                  busy_o
);

    // Beat counts (not beats-1) need one extra bit so len=all-ones fits.
    localparam int RW = LEN_WIDTH + 1;

    sched_state_t          state;
    logic                  cfg_gnt;
    logic                  mem_gnt;
    logic                  req_is_mem;
    logic [RW-1:0]         rem_beats;
    logic [RW-1:0]         limit_r;
    logic [RW-1:0]         new_beats;
    logic [RW-1:0]         new_limit;
    logic [RW-1:0]         new_chunk;
    logic [RW-1:0]         next_chunk;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [GAP_WIDTH-1:0]  gap_cnt;

    // Beats to issue in the next command; a limit of 0 means unlimited.
    function automatic logic [RW-1:0] chunk_beats(input logic [RW-1:0] beats,
                                                  input logic [RW-1:0] limit);
        if ((limit != '0) && (beats > limit)) begin
            return limit;
        end
        return beats;
    endfunction

    // Byte distance covered by a chunk; wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] chunk_bytes(input logic [RW-1:0] beats);
        return ADDR_WIDTH'(beats) * ADDR_WIDTH'(BEAT_BYTES);
    endfunction

    psram_sched_rr_arb2 u_arb (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .enable  (en_i & (state == PSRAM_SCHED_IDLE)),
        .cfg_req (cfg_valid_i),
        .mem_req (mem_valid_i),
        .cfg_gnt (cfg_gnt),
        .mem_gnt (mem_gnt)
    );

    assign cfg_ready_o = cfg_gnt;
    assign mem_ready_o = mem_gnt;
    assign busy_o      = (state != PSRAM_SCHED_IDLE);

    assign new_beats = RW'(mem_len_i) + RW'(1);

`ifdef PSRAM_BURST_SPLIT_EN
    assign new_limit = (max_beats_i == '0) ? '0 : (RW'(max_beats_i) + RW'(1));
`else
    logic unused_max_beats;
    assign unused_max_beats = ^max_beats_i;
    assign new_limit        = '0;
`endif

    assign new_chunk  = chunk_beats(new_beats, new_limit);
    assign next_chunk = chunk_beats(rem_beats, limit_r);

    // Scheduler FSM: accept, issue, wait for the core, then hold CE high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= PSRAM_SCHED_IDLE;
            core_start_o <= 1'b0;
            core_type_o  <= 2'd0;
            core_addr_o  <= '0;
            core_len_o   <= '0;
            cfg_done_o   <= 1'b0;
            mem_done_o   <= 1'b0;
            req_is_mem   <= 1'b0;
            rem_beats    <= '0;
            limit_r      <= '0;
            next_addr    <= '0;
            gap_cnt      <= '0;
        end else begin
            core_start_o <= 1'b0;
            cfg_done_o   <= 1'b0;
            mem_done_o   <= 1'b0;
            case (state)
                PSRAM_SCHED_IDLE: begin
                    if (cfg_gnt) begin
                        core_type_o  <= cmd_type(1'b0, cfg_wr_i);
                        core_addr_o  <= ADDR_WIDTH'(cfg_ma_i);
                        core_len_o   <= '0;
                        req_is_mem   <= 1'b0;
                        rem_beats    <= '0;
                        limit_r      <= '0;
                        core_start_o <= 1'b1;
                        state        <= PSRAM_SCHED_ISSUE;
                    end else if (mem_gnt) begin
                        core_type_o  <= cmd_type(1'b1, mem_wr_i);
                        core_addr_o  <= mem_addr_i;
                        core_len_o   <= LEN_WIDTH'(new_chunk - RW'(1));
                        req_is_mem   <= 1'b1;
                        rem_beats    <= new_beats - new_chunk;
                        limit_r      <= new_limit;
                        next_addr    <= mem_addr_i + chunk_bytes(new_chunk);
                        core_start_o <= 1'b1;
                        state        <= PSRAM_SCHED_ISSUE;
                    end
                end
                PSRAM_SCHED_ISSUE: begin
                    state <= PSRAM_SCHED_WAIT;
                end
                PSRAM_SCHED_WAIT: begin
                    if (core_done_i) begin
                        gap_cnt <= tcph_i;
                        state   <= PSRAM_SCHED_GAP;
                        // Done is reported only once the last chunk completes.
                        if (rem_beats == '0) begin
                            if (req_is_mem) begin
                                mem_done_o <= 1'b1;
                            end else begin
                                cfg_done_o <= 1'b1;
                            end
                        end
                    end
                end
                PSRAM_SCHED_GAP: begin
                    if (gap_cnt == '0) begin
                        if (rem_beats != '0) begin
                            core_addr_o  <= next_addr;
                            core_len_o   <= LEN_WIDTH'(next_chunk - RW'(1));
                            rem_beats    <= rem_beats - next_chunk;
                            next_addr    <= next_addr + chunk_bytes(next_chunk);
                            core_start_o <= 1'b1;
                            state        <= PSRAM_SCHED_ISSUE;
                        end else begin
                            state <= PSRAM_SCHED_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    state <= PSRAM_SCHED_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_sched.sv
// tb_psram_sched: self-checking bench for psram_sched with a behavioural
// core responder and a chunk-list reference model.
module tb_psram_sched;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int GW = 4;
    localparam int BB = 2;

`ifdef PSRAM_BURST_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          en_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic          cfg_wr_i;
    logic [7:0]    cfg_ma_i;
    logic          mem_valid_i;
    logic          mem_ready_o;
    logic          mem_wr_i;
    logic [AW-1:0] mem_addr_i;
    logic [LW-1:0] mem_len_i;
    logic [GW-1:0] tcph_i;
    logic [LW-1:0] max_beats_i;
    logic          core_start_o;
    logic [1:0]    core_type_o;
    logic [AW-1:0] core_addr_o;
    logic [LW-1:0] core_len_o;
    logic          core_done_i;
    logic          cfg_done_o;
    logic          mem_done_o;
    logic          busy_o;

    always #5 clk = ~clk;

    psram_sched #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .GAP_WIDTH  (GW),
        .BEAT_BYTES (BB)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_ma_i     (cfg_ma_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_wr_i     (mem_wr_i),
        .mem_addr_i   (mem_addr_i),
        .mem_len_i    (mem_len_i),
        .tcph_i       (tcph_i),
        .max_beats_i  (max_beats_i),
        .core_start_o (core_start_o),
        .core_type_o  (core_type_o),
        .core_addr_o  (core_addr_o),
        .core_len_o   (core_len_o),
        .core_done_i  (core_done_i),
        .cfg_done_o   (cfg_done_o),
        .mem_done_o   (mem_done_o),
        .busy_o       (busy_o)
    );

    int total = 0;
    int bad   = 0;

    bit auto_core  = 1'b0;
    int core_delay = 2;

    logic [1:0]    obs_type[$];
    logic [AW-1:0] obs_addr[$];
    logic [LW-1:0] obs_len[$];
    logic [1:0]    exp_type[$];
    logic [AW-1:0] exp_addr[$];
    logic [LW-1:0] exp_len[$];
    int cfg_done_cnt = 0;
    int mem_done_cnt = 0;
    int mem_done_at  = 0;
    int busy_cnt     = 0;

    // Observe outputs just after each active edge.
    always begin
        @(posedge clk);
        #1;
        if (core_start_o) begin
            obs_type.push_back(core_type_o);
            obs_addr.push_back(core_addr_o);
            obs_len.push_back(core_len_o);
        end
        if (cfg_done_o) cfg_done_cnt++;
        if (mem_done_o) begin
            mem_done_cnt++;
            mem_done_at = obs_type.size();
        end
        if (busy_o) busy_cnt++;
    end

    // Behavioural core: answer every command with a done pulse after core_delay cycles.
    always begin
        @(posedge clk);
        #1;
        if (auto_core && core_start_o) begin
            repeat (core_delay) @(posedge clk);
            #1;
            core_done_i = 1'b1;
            @(posedge clk);
            #1;
            core_done_i = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic clear_obs();
        obs_type.delete(); obs_addr.delete(); obs_len.delete();
        exp_type.delete(); exp_addr.delete(); exp_len.delete();
        cfg_done_cnt = 0; mem_done_cnt = 0; mem_done_at = 0; busy_cnt = 0;
    endtask

    // Reference chunk list for a memory request, from the burst rules.
    task automatic model_mem(input logic wr, input logic [AW-1:0] addr, input int len, input int maxb);
        int beats;
        int step;
        int c;
        logic [AW-1:0] a;
        beats = len + 1;
        step  = (SPLIT && maxb != 0) ? maxb + 1 : beats;
        a     = addr;
        while (beats > 0) begin
            c = (beats < step) ? beats : step;
            exp_type.push_back({1'b1, wr});
            exp_addr.push_back(a);
            exp_len.push_back(LW'(c - 1));
            a = a + AW'(c * BB);
            beats = beats - c;
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; en_i = 1'b0; cfg_valid_i = 1'b0; mem_valid_i = 1'b0;
        core_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input bit is_cfg, input logic wr, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, output bit ok);
        ok = 1'b0;
        if (is_cfg) begin
            cfg_wr_i = wr; cfg_ma_i = addr[7:0]; cfg_valid_i = 1'b1;
        end else begin
            mem_wr_i = wr; mem_addr_i = addr; mem_len_i = len; mem_valid_i = 1'b1;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (is_cfg ? cfg_ready_o : mem_ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cfg_valid_i = 1'b0;
        mem_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; en_i = 1'b0; cfg_valid_i = 1'b0; mem_valid_i = 1'b0;
        cfg_wr_i = 1'b0; cfg_ma_i = '0; mem_wr_i = 1'b0; mem_addr_i = '0; mem_len_i = '0;
        tcph_i = '0; max_beats_i = '0; core_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy_o, core_start_o, cfg_done_o, mem_done_o} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b required 0000", {busy_o, core_start_o, cfg_done_o, mem_done_o});
        end
        total++;
        if ({core_type_o, core_addr_o, core_len_o} !== '0) begin
            bad++; $display("FAIL reset_fields: got %0h/%0h/%0h required 0", core_type_o, core_addr_o, core_len_o);
        end
        total++;
        if ({cfg_ready_o, mem_ready_o} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b required 00", {cfg_ready_o, mem_ready_o});
        end
        rst_n_i = 1'b1;
        cfg_valid_i = 1'b1; mem_valid_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({cfg_ready_o, mem_ready_o, busy_o} !== 3'b000) begin
            bad++; $display("FAIL disabled_ready: got %b required 000", {cfg_ready_o, mem_ready_o, busy_o});
        end
        cfg_valid_i = 1'b0; mem_valid_i = 1'b0;
    endtask

    task automatic test_cfg_write();
        clear_obs();
        auto_core = 1'b0;
        en_i = 1'b1; tcph_i = 4'd3; cfg_wr_i = 1'b1; cfg_ma_i = 8'h04; cfg_valid_i = 1'b1;
        #1;
        total++;
        if ({cfg_ready_o, mem_ready_o} !== 2'b10) begin
            bad++; $display("FAIL cfg_ready: got %b required 10", {cfg_ready_o, mem_ready_o});
        end
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
        total++;
        if (core_start_o !== 1'b1) begin
            bad++; $display("FAIL cfg_start_latency: got %b required 1", core_start_o);
        end
        total++;
        if ({core_type_o, core_addr_o, core_len_o} !== {2'd1, 32'h4, 8'h0}) begin
            bad++; $display("FAIL cfg_cmd: got %0d/%0h/%0d required 1/4/0", core_type_o, core_addr_o, core_len_o);
        end
        @(posedge clk);
        #1;
        total++;
        if ({core_start_o, busy_o} !== 2'b01) begin
            bad++; $display("FAIL cfg_start_width: got %b required 01", {core_start_o, busy_o});
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({core_type_o, core_addr_o} !== {2'd1, 32'h4}) begin
            bad++; $display("FAIL cfg_hold: got %0d/%0h required 1/4", core_type_o, core_addr_o);
        end
        core_done_i = 1'b1;
        @(posedge clk);
        #1;
        core_done_i = 1'b0;
        total++;
        if (cfg_done_o !== 1'b1) begin
            bad++; $display("FAIL cfg_done_pulse: got %b required 1", cfg_done_o);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy_o, cfg_done_cnt} !== {1'b1, 32'd1}) begin
            bad++; $display("FAIL cfg_gap_busy: busy=%b dones=%0d required 1/1", busy_o, cfg_done_cnt);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL cfg_gap_end: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        do_reset();
        clear_obs();
        auto_core = 1'b1; core_delay = 2;
        en_i = 1'b1; tcph_i = '0; max_beats_i = '0;
        cfg_wr_i = 1'b1; cfg_ma_i = 8'h5A; mem_wr_i = 1'b0; mem_addr_i = 32'h40; mem_len_i = '0;
        cfg_valid_i = 1'b1; mem_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (obs_type.size() >= 4) ok = 1'b1;
        end
        cfg_valid_i = 1'b0; mem_valid_i = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL arb_timeout: got %0d commands required 4", obs_type.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_type[i] !== ((i % 2 == 0) ? 2'd1 : 2'd2)) begin
                    bad++; $display("FAIL arb_order[%0d]: got type %0d required %0d", i, obs_type[i], (i % 2 == 0) ? 1 : 2);
                end
            end
            total++;
            if (obs_addr[0] !== 32'h5A) begin
                bad++; $display("FAIL arb_cfg_addr: got %0h required 5a", obs_addr[0]);
            end
        end
        wait_idle(100, ok);
    endtask

    task automatic test_split();
        bit ok;
        int n;
        logic [AW-1:0] ea[3];
        logic [LW-1:0] el[3];
        clear_obs();
        auto_core = 1'b1; core_delay = 3;
        en_i = 1'b1; tcph_i = 4'd2; max_beats_i = 8'd3;
        if (SPLIT) begin
            n = 3;
            ea[0] = 32'h100; ea[1] = 32'h108; ea[2] = 32'h110;
            el[0] = 8'd3;    el[1] = 8'd3;    el[2] = 8'd1;
        end else begin
            n = 1;
            ea[0] = 32'h100; el[0] = 8'd9;
            ea[1] = '0; ea[2] = '0; el[1] = '0; el[2] = '0;
        end
        issue_req(1'b0, 1'b0, 32'h100, 8'd9, ok);
        if (ok) wait_idle(300, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL split_timeout: request did not complete");
        end
        total++;
        if (obs_type.size() !== n) begin
            bad++; $display("FAIL split_count: got %0d commands required %0d", obs_type.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                total++;
                if ({obs_type[i], obs_addr[i], obs_len[i]} !== {2'd2, ea[i], el[i]}) begin
                    bad++; $display("FAIL split_chunk[%0d]: got %0d/%0h/%0d required 2/%0h/%0d", i, obs_type[i], obs_addr[i], obs_len[i], ea[i], el[i]);
                end
            end
        end
        total++;
        if ({mem_done_cnt, mem_done_at, cfg_done_cnt} !== {32'd1, 32'(n), 32'd0}) begin
            bad++; $display("FAIL split_done: got cnt=%0d at=%0d cfg=%0d required 1/%0d/0", mem_done_cnt, mem_done_at, cfg_done_cnt, n);
        end
        total++;
        if (busy_cnt !== n * (3 + 2 + 2)) begin
            bad++; $display("FAIL split_busy: got %0d cycles required %0d", busy_cnt, n * 7);
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        bit leak;
        clear_obs();
        auto_core = 1'b1; core_delay = 4;
        en_i = 1'b1; tcph_i = 4'd1; max_beats_i = '0;
        issue_req(1'b0, 1'b1, 32'h200, 8'd2, ok);
        en_i = 1'b0;
        cfg_wr_i = 1'b0; cfg_ma_i = 8'h22;
        cfg_valid_i = 1'b1; mem_valid_i = 1'b1;
        leak = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(posedge clk);
                #1;
                if (cfg_ready_o || mem_ready_o) leak = 1'b1;
                if (!busy_o) ok = 1'b1;
            end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL en_drop_timeout: request did not complete");
        end
        total++;
        if ({mem_done_cnt, obs_type.size()} !== {32'd1, 32'd1}) begin
            bad++; $display("FAIL en_drop_done: got dones=%0d cmds=%0d required 1/1", mem_done_cnt, obs_type.size());
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (cfg_ready_o || mem_ready_o || busy_o) leak = 1'b1;
        end
        total++;
        if (leak !== 1'b0) begin
            bad++; $display("FAIL en_drop_ready: got ready while disabled, required none");
        end
        en_i = 1'b1;
        #1;
        total++;
        if ({cfg_ready_o, mem_ready_o} !== 2'b10) begin
            bad++; $display("FAIL en_return_ready: got %b required 10", {cfg_ready_o, mem_ready_o});
        end
        cfg_valid_i = 1'b0; mem_valid_i = 1'b0;
    endtask

    task automatic test_stray_done();
        bit ok;
        clear_obs();
        auto_core = 1'b0;
        en_i = 1'b1; tcph_i = '0; max_beats_i = '0;
        issue_req(1'b0, 1'b1, 32'h80, 8'd1, ok);
        core_done_i = 1'b1;
        @(posedge clk);
        #1;
        core_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ok, busy_o, core_start_o, mem_done_cnt} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL stray_done_issue: got ok=%b busy=%b start=%b dones=%0d required 1/1/0/0", ok, busy_o, core_start_o, mem_done_cnt);
        end
        core_done_i = 1'b1;
        @(posedge clk);
        #1;
        core_done_i = 1'b0;
        total++;
        if (mem_done_o !== 1'b1) begin
            bad++; $display("FAIL stray_done_real: got %b required 1", mem_done_o);
        end
        wait_idle(20, ok);
        total++;
        if ({ok, mem_done_cnt} !== {1'b1, 32'd1}) begin
            bad++; $display("FAIL stray_done_finish: got ok=%b dones=%0d required 1/1", ok, mem_done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        auto_core = 1'b0;
        en_i = 1'b1; tcph_i = 4'd2; max_beats_i = '0;
        issue_req(1'b1, 1'b0, 32'h33, 8'd0, ok);
        @(posedge clk);
        #1;
        core_done_i = 1'b1;
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({busy_o, core_start_o, cfg_done_o, mem_done_o, core_type_o, core_addr_o, core_len_o} !== '0) begin
            bad++; $display("FAIL reset_mid_out: got busy=%b start=%b type=%0d addr=%0h required all 0", busy_o, core_start_o, core_type_o, core_addr_o);
        end
        @(posedge clk);
        #1;
        total++;
        if ({cfg_done_o, cfg_done_cnt} !== {1'b0, 32'd0}) begin
            bad++; $display("FAIL reset_mid_done: got pulse=%b count=%0d required 0/0", cfg_done_o, cfg_done_cnt);
        end
        core_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        auto_core = 1'b1; core_delay = 2;
        cfg_valid_i = 1'b1; mem_valid_i = 1'b1; cfg_wr_i = 1'b0; cfg_ma_i = 8'h11;
        #1;
        total++;
        if ({cfg_ready_o, mem_ready_o} !== 2'b10) begin
            bad++; $display("FAIL reset_mid_grant: got %b required 10", {cfg_ready_o, mem_ready_o});
        end
        mem_valid_i = 1'b0;
        issue_req(1'b1, 1'b0, 32'h11, 8'd0, ok);
        if (ok) wait_idle(50, ok);
        total++;
        if ({ok, obs_type.size(), cfg_done_cnt} !== {1'b1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL reset_mid_next: got ok=%b cmds=%0d dones=%0d required 1/1/1", ok, obs_type.size(), cfg_done_cnt);
        end else begin
            total++;
            if ({obs_type[0], obs_addr[0], obs_len[0]} !== {2'd0, 32'h11, 8'd0}) begin
                bad++; $display("FAIL reset_mid_cmd: got %0d/%0h/%0d required 0/11/0", obs_type[0], obs_addr[0], obs_len[0]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        bit is_cfg;
        logic wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int maxb;
        int tc;
        int n;
        auto_core = 1'b1;
        en_i = 1'b1;
        for (int it = 0; it < 25; it++) begin
            clear_obs();
            is_cfg = ($urandom_range(0, 3) == 0);
            wr     = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
            len    = LW'($urandom_range(0, 20));
            maxb   = $urandom_range(0, 6);
            tc     = $urandom_range(0, 3);
            core_delay  = $urandom_range(1, 4);
            tcph_i      = GW'(tc);
            max_beats_i = LW'(maxb);
            if (is_cfg) begin
                exp_type.push_back({1'b0, wr});
                exp_addr.push_back({24'h0, addr[7:0]});
                exp_len.push_back('0);
            end else begin
                model_mem(wr, addr, int'(len), maxb);
            end
            n = exp_type.size();
            issue_req(is_cfg, wr, addr, len, ok);
            if (ok) wait_idle(2000, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL rand[%0d]_timeout: request did not complete", it);
            end
            total++;
            if (obs_type.size() !== n) begin
                bad++; $display("FAIL rand[%0d]_count: got %0d commands required %0d", it, obs_type.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    total++;
                    if ({obs_type[i], obs_addr[i], obs_len[i]} !== {exp_type[i], exp_addr[i], exp_len[i]}) begin
                        bad++; $display("FAIL rand[%0d]_cmd[%0d]: got %0d/%0h/%0d required %0d/%0h/%0d", it, i, obs_type[i], obs_addr[i], obs_len[i], exp_type[i], exp_addr[i], exp_len[i]);
                    end
                end
            end
            total++;
            if ({cfg_done_cnt, mem_done_cnt} !== (is_cfg ? {32'd1, 32'd0} : {32'd0, 32'd1})) begin
                bad++; $display("FAIL rand[%0d]_done: got cfg=%0d mem=%0d required %0d/%0d", it, cfg_done_cnt, mem_done_cnt, is_cfg, !is_cfg);
            end
            if (!is_cfg) begin
                total++;
                if (mem_done_at !== n) begin
                    bad++; $display("FAIL rand[%0d]_done_at: got after %0d commands required %0d", it, mem_done_at, n);
                end
            end
            total++;
            if (busy_cnt !== n * (core_delay + tc + 2)) begin
                bad++; $display("FAIL rand[%0d]_busy: got %0d cycles required %0d", it, busy_cnt, n * (core_delay + tc + 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_arbitration();
        test_split();
        test_en_drop();
        test_stray_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
